gan_frame_serializer: RTL and testbench
=======================================

// Module: gan_frame_serializer
// PURPOSE
//  Transmit side of the GAN pixel stream: captures a flattened Q8.8 frame (e.g. generated_frame_flat
//  from gan_serial_top on generated_frame_valid) and streams it out one pixel per valid/ready beat.
//  Each beat carries the 16-bit word plus a thresholded bit, i.e. the same 1-bit-per-pixel format the
//  serial input port consumes, so generated frames can be looped back or dumped by hardware.
// PARAMETERS
//  PIXEL_COUNT  784      pixels per frame (28x28)
//  PIXEL_WIDTH  16       bits per pixel, signed Q8.8
//  THRESHOLD    16'h0080 signed Q8.8 binarization threshold (0.5)
// PORTS
//  clk          in   1                    clock, all logic on rising edge
//  rst_n        in   1                    synchronous active-low reset
//  frame_flat   in   PIXEL_WIDTH*PIXEL_COUNT  frame; pixel i at [(i+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]
//  frame_valid  in   1                    frame_flat valid, request to load
//  frame_ready  out  1                    high in IDLE only; load accepted when frame_valid&&frame_ready
//  out_word     out  PIXEL_WIDTH          current pixel word
//  out_bit      out  1                    $signed(out_word) >= $signed(THRESHOLD)
//  out_index    out  $clog2(PIXEL_COUNT)  index of current pixel
//  out_last     out  1                    high with beat index PIXEL_COUNT-1
//  out_valid    out  1                    beat valid
//  out_ready    in   1                    sink accepts beat
//  busy         out  1                    high in STREAM and DONE
//  frame_done   out  1                    one-cycle pulse after last beat accepted
//  frame_dropped out 1                    one-cycle pulse: frame_valid seen while not frame_ready
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, index=0; out_valid, out_last, out_bit, out_word, busy,
//   frame_done, frame_dropped all 0; frame_ready 0 during reset, 1 from first cycle after release.
//  Reset mid-stream aborts the frame: no further beats, no frame_done; captured frame discarded.
//  FSM: IDLE -> STREAM -> DONE -> IDLE.
//  IDLE: frame_ready=1. On frame_valid: latch full frame_flat into internal buffer, index=0, go STREAM.
//   Latency: out_valid rises the cycle after the capture edge with pixel 0.
//  STREAM: out_valid=1; out_word=buffer[index]; out_bit, out_last combinational from buffer[index]/index.
//   Handshake = out_valid && out_ready at rising edge. On handshake: if out_last -> DONE (out_valid=0
//   next cycle), else index+1. Without handshake all out_* hold stable (AXI-style; no retraction).
//   Throughput: one beat per cycle with out_ready held high; frame = 1 + PIXEL_COUNT + 1 cycles.
//  DONE: one cycle, frame_done=1, out_valid=0, frame_ready=0; then IDLE.
//  frame_valid in STREAM/DONE: ignored, frame_dropped=1 for that cycle; buffer and stream untouched.
//  frame_flat changes after capture have no effect on the stream.
//  out_bit comparison is full-width signed: 0x8000..0xFFFF (negative) -> 0.
//  index never exceeds PIXEL_COUNT-1; no wrap, no partial frames.
// TESTING
//  T1 reset: rst_n=0 for 3 cycles at beat 100 -> out_valid=0, busy=0, no frame_done; frame_ready=1 after.
//  T2 ramp frame pixel[i]=i, out_ready=1 -> 784 beats on 784 consecutive cycles, out_word=out_index=i,
//     out_last only at 783, frame_done exactly one cycle after beat 783, frame_ready the cycle after.
//  T3 threshold: pixels 0x007F,0x0080,0xFF00,0x7FFF -> out_bit 0,1,0,1.
//  T4 backpressure: random out_ready (50%) -> out_* stable while stalled, 784 beats, no loss/duplicate.
//  T5 frame_valid pulsed with new data during STREAM -> frame_dropped=1 that cycle, stream = first frame.
//  T6 back-to-back: frame_valid held high -> second frame captured on first IDLE cycle after frame_done.

Source files
------------

// File: rtl/gan_frame_serializer.sv
// Captures a flattened Q8.8 frame and streams it out one pixel per valid/ready beat,
// each beat carrying the 16-bit word plus its thresholded 1-bit value.
module gan_frame_serializer #(
  parameter int unsigned PIXEL_COUNT = 784,
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter logic [PIXEL_WIDTH-1:0] THRESHOLD = 16'h0080
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PIXEL_WIDTH*PIXEL_COUNT-1:0] frame_flat,
  input  logic                               frame_valid,
  output logic                               frame_ready,
  output logic [PIXEL_WIDTH-1:0]             out_word,
  output logic                               out_bit,
  output logic [$clog2(PIXEL_COUNT)-1:0]     out_index,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               frame_dropped
);

  localparam int unsigned IDX_W = $clog2(PIXEL_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                 r_state;
  logic [PIXEL_WIDTH-1:0] r_buf [PIXEL_COUNT];
  logic [IDX_W-1:0]       r_index;
  logic [PIXEL_WIDTH-1:0] r_word;
  logic                   r_bit;
  logic                   r_last;
  logic                   r_valid;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_dropped;

  logic                   w_capture;
  logic                   w_beat;
  logic [IDX_W-1:0]       w_next_idx;
  logic [PIXEL_WIDTH-1:0] w_next_word;
  logic [PIXEL_WIDTH-1:0] w_pix0;

  function automatic logic f_above(input logic [PIXEL_WIDTH-1:0] w);
    return $signed(w) >= $signed(THRESHOLD);
  endfunction

  always_comb begin
    w_capture   = frame_valid && r_ready;
    w_beat      = r_valid && out_ready;
    w_next_idx  = r_index + IDX_W'(1);
    w_next_word = r_buf[w_next_idx];
    w_pix0      = frame_flat[PIXEL_WIDTH-1:0];
  end

  // Frame buffer: datapath only, contents irrelevant until a capture refills it.
  always_ff @(posedge clk) begin
    if (rst_n && w_capture) begin
      for (int i = 0; i < int'(PIXEL_COUNT); i++) begin
        r_buf[i] <= frame_flat[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
  end

  // Control FSM; the word/bit/last of the next beat are prefetched so all outputs are flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_index   <= '0;
      r_word    <= '0;
      r_bit     <= 1'b0;
      r_last    <= 1'b0;
      r_valid   <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_dropped <= frame_valid && !r_ready;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_state <= S_STREAM;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_index <= '0;
            r_word  <= w_pix0;
            r_bit   <= f_above(w_pix0);
            r_last  <= (PIXEL_COUNT == 1);
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_beat) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_bit   <= 1'b0;
              r_word  <= '0;
              r_index <= '0;
              r_done  <= 1'b1;
            end else begin
              r_index <= w_next_idx;
              r_word  <= w_next_word;
              r_bit   <= f_above(w_next_word);
              r_last  <= (w_next_idx == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign frame_ready   = r_ready;
  assign out_word      = r_word;
  assign out_bit       = r_bit;
  assign out_index     = r_index;
  assign out_last      = r_last;
  assign out_valid     = r_valid;
  assign busy          = r_busy;
  assign frame_done    = r_done;
  assign frame_dropped = r_dropped;

endmodule

// File: tb/tb_gan_frame_serializer.sv
// Directed bench for gan_frame_serializer: reset, ramp, threshold, backpressure, drop, back-to-back.
module tb_gan_frame_serializer;

  localparam int unsigned PC = 784;
  localparam int unsigned PW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PW*PC-1:0] frame_flat;
  logic            frame_valid;
  logic            frame_ready;
  logic [PW-1:0]   out_word;
  logic            out_bit;
  logic [9:0]      out_index;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            frame_done;
  logic            frame_dropped;

  logic [PW-1:0]   exp_pix [PC];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  gan_frame_serializer dut (
    .clk(clk), .rst_n(rst_n), .frame_flat(frame_flat), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .out_word(out_word), .out_bit(out_bit), .out_index(out_index),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_done(frame_done), .frame_dropped(frame_dropped)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_bit(input logic [PW-1:0] p);
    return $signed(p) >= $signed(16'sh0080);
  endfunction

  task automatic load_frame();
    for (int i = 0; i < int'(PC); i++) frame_flat[i*PW +: PW] = exp_pix[i];
  endtask

  // Present exp_pix as a frame for one edge; leaves the sample point right after capture.
  task automatic start_frame(input string tag, input bit hold);
    load_frame();
    frame_valid = 1'b1;
    tick();
    frame_valid = hold;
    check_eq({tag, "_valid_after_capture"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_ready_low_streaming"}, 32'(frame_ready), 32'd0);
  endtask

  // Consumes beats from `first` onward until frame_done, scoring each against exp_pix.
  task automatic run_stream(input int first, input bit rand_rdy, input int pulse_at, input bit hold,
                            output int cycles, output int beats, output int data_err,
                            output int stall_err, output int stalls, output int drops,
                            output bit done_seen);
    logic [PW-1:0] pw;
    logic [9:0]    pi;
    logic          pl, pb;
    bit            prev_stall, pulsed;
    cycles = 0; beats = first; data_err = 0; stall_err = 0; stalls = 0; drops = 0;
    done_seen = 1'b0; prev_stall = 1'b0; pulsed = 1'b0;
    pw = '0; pi = '0; pl = 1'b0; pb = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (frame_dropped) drops++;
      if (frame_done) begin
        done_seen = 1'b1;
        break;
      end
      if (prev_stall && (!out_valid || out_word !== pw || out_index !== pi ||
                         out_last !== pl || out_bit !== pb)) stall_err++;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        cycles++;
        if (beats >= int'(PC)) data_err++;
        else if (out_word !== exp_pix[beats] || out_index !== 10'(beats) ||
                 out_last !== (beats == int'(PC) - 1) || out_bit !== model_bit(exp_pix[beats]))
          data_err++;
        pw = out_word; pi = out_index; pl = out_last; pb = out_bit;
        prev_stall = !out_ready;
        if (out_ready) beats++;
        else stalls++;
      end else begin
        data_err++;
        prev_stall = 1'b0;
      end
      frame_valid = hold || (beats == pulse_at && !pulsed);
      if (frame_valid && !hold) begin
        frame_flat = '1;
        pulsed = 1'b1;
      end
      tick();
    end
    frame_valid = hold;
  endtask

  // At the frame_done sample: check the DONE cycle, then the return to IDLE.
  task automatic finish_frame(input string tag, input bit done_seen);
    check_eq({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    check_eq({tag, "_done_valid_low"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_done_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_done_ready_low"}, 32'(frame_ready), 32'd0);
    tick();
    check_eq({tag, "_done_pulse_ends"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_ready_after_done"}, 32'(frame_ready), 32'd1);
    check_eq({tag, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  cyc, bts, derr, serr, stl, drp;
    bit  dn;
    rst_n = 1'b0; frame_valid = 1'b0; out_ready = 1'b0; frame_flat = '0;

    // Power-on reset
    repeat (3) tick();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(frame_ready), 32'd0);
    check_eq("rst_word", 32'(out_word), 32'd0);
    check_eq("rst_index", 32'(out_index), 32'd0);
    check_eq("rst_flags", 32'({out_bit, out_last, frame_done, frame_dropped}), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_release_ready", 32'(frame_ready), 32'd1);

    // T2 ramp, full throughput
    for (int i = 0; i < int'(PC); i++) exp_pix[i] = PW'(i);
    start_frame("t2", 1'b0);
    check_eq("t2_busy", 32'(busy), 32'd1);
    run_stream(0, 1'b0, -1, 1'b0, cyc, bts, derr, serr, stl, drp, dn);
    check_eq("t2_valid_cycles", 32'(cyc), 32'(PC));
    check_eq("t2_beats", 32'(bts), 32'(PC));
    check_eq("t2_beat_errs", 32'(derr), 32'd0);
    finish_frame("t2", dn);

    // T3 threshold boundaries
    for (int i = 0; i < int'(PC); i++) exp_pix[i] = 16'h0100;
    exp_pix[0] = 16'h007F; exp_pix[1] = 16'h0080; exp_pix[2] = 16'hFF00; exp_pix[3] = 16'h7FFF;
    start_frame("t3", 1'b0);
    out_ready = 1'b1;
    check_eq("t3_bit_007f", 32'(out_bit), 32'd0);
    tick();
    check_eq("t3_bit_0080", 32'(out_bit), 32'd1);
    tick();
    check_eq("t3_bit_ff00", 32'(out_bit), 32'd0);
    tick();
    check_eq("t3_bit_7fff", 32'(out_bit), 32'd1);
    run_stream(3, 1'b0, -1, 1'b0, cyc, bts, derr, serr, stl, drp, dn);
    check_eq("t3_beat_errs", 32'(derr), 32'd0);
    finish_frame("t3", dn);

    // T4 random backpressure
    for (int i = 0; i < int'(PC); i++) exp_pix[i] = PW'((i * 37 + 5) ^ 16'hA5A5);
    start_frame("t4", 1'b0);
    run_stream(0, 1'b1, -1, 1'b0, cyc, bts, derr, serr, stl, drp, dn);
    check_eq("t4_beats", 32'(bts), 32'(PC));
    check_eq("t4_beat_errs", 32'(derr), 32'd0);
    check_eq("t4_stall_unstable", 32'(serr), 32'd0);
    check_eq("t4_stalls_seen", 32'(stl != 0), 32'd1);
    finish_frame("t4", dn);

    // T1 reset mid-stream at beat 100
    for (int i = 0; i < int'(PC); i++) exp_pix[i] = PW'(i + 16'h0200);
    start_frame("t1", 1'b0);
    out_ready = 1'b1;
    repeat (100) tick();
    check_eq("t1_index_100", 32'(out_index), 32'd100);
    rst_n = 1'b0;
    repeat (3) begin
      tick();
      check_eq("t1_rst_valid", 32'(out_valid), 32'd0);
      check_eq("t1_rst_busy_done", 32'({busy, frame_done}), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_eq("t1_ready_after", 32'(frame_ready), 32'd1);
    repeat (5) tick();
    check_eq("t1_no_resume", 32'({out_valid, busy, frame_done}), 32'd0);

    // T5 frame_valid pulse mid-stream is dropped
    for (int i = 0; i < int'(PC); i++) exp_pix[i] = PW'(16'h1000 + i);
    start_frame("t5", 1'b0);
    run_stream(0, 1'b0, 10, 1'b0, cyc, bts, derr, serr, stl, drp, dn);
    check_eq("t5_drops", 32'(drp), 32'd1);
    check_eq("t5_beat_errs", 32'(derr), 32'd0);
    check_eq("t5_beats", 32'(bts), 32'(PC));
    finish_frame("t5", dn);

    // T6 frame_valid held: second frame captured on the first IDLE cycle
    for (int i = 0; i < int'(PC); i++) exp_pix[i] = PW'(16'h3000 - i);
    start_frame("t6a", 1'b1);
    run_stream(0, 1'b0, -1, 1'b1, cyc, bts, derr, serr, stl, drp, dn);
    check_eq("t6a_beat_errs", 32'(derr), 32'd0);
    check_eq("t6a_drops", 32'(drp), 32'(PC));
    finish_frame("t6a", dn);
    for (int i = 0; i < int'(PC); i++) exp_pix[i] = PW'(16'h5000 + 3 * i);
    load_frame();
    tick();
    frame_valid = 1'b0;
    check_eq("t6b_captured", 32'(out_valid), 32'd1);
    check_eq("t6b_pix0", 32'(out_word), 32'h5000);
    run_stream(0, 1'b0, -1, 1'b0, cyc, bts, derr, serr, stl, drp, dn);
    check_eq("t6b_beat_errs", 32'(derr), 32'd0);
    check_eq("t6b_beats", 32'(bts), 32'(PC));
    finish_frame("t6b", dn);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
